// File: rtl/button_frontend.sv
// rtl/button_frontend.sv - pushbutton/tilt synchroniser, debouncer and test-mode front end
//
// Purpose: synchronises and debounces five active-low pushbuttons and the tilt
// switch, then produces one-cycle command pulses, the tilt level, the test-mode
// level and the test-mode press count for the central FSM.
//
// Ports:
//   clk          system clock (only clock)
//   rst          synchronous active-high reset
//   raw_sleep_n  sleep button, active-low, asynchronous
//   raw_awake_n  awake button, active-low, asynchronous
//   raw_feed_n   feed button, active-low, asynchronous
//   raw_play_n   play button, active-low, asynchronous
//   raw_test_n   test button, active-low, asynchronous
//   raw_giro     tilt switch, active-high, asynchronous
//   botonSleep   one-cycle pulse per sleep press
//   botonAwake   one-cycle pulse per awake press
//   botonFeed    one-cycle pulse per feed press
//   botonPlay    one-cycle pulse per play press
//   giro         debounced tilt level
//   botonTest    high while test mode is active
//   BpulseTest   test-mode press count, 0..9
module button_frontend #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_sleep_n,
    input  logic       raw_awake_n,
    input  logic       raw_feed_n,
    input  logic       raw_play_n,
    input  logic       raw_test_n,
    input  logic       raw_giro,
    output logic       botonSleep,
    output logic       botonAwake,
    output logic       botonFeed,
    output logic       botonPlay,
    output logic       giro,
    output logic       botonTest,
    output logic [3:0] BpulseTest
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_TEST   = 1'b1;

    // Channel order: 0 sleep, 1 awake, 2 feed, 3 play, 4 test, 5 tilt.
    // Idle raw level per channel; XOR with it turns raw pins into "pressed" = 1.
    localparam logic [5:0] RAW_IDLE = 6'b011111;
    localparam int CH_TEST = 4;
    localparam int CH_GIRO = 5;

    logic [5:0]      raw_vec;
    logic [5:0]      sync1_q, sync2_q;
    logic [5:0]      pressed;
    logic [5:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [6];
    logic [DB_W-1:0] db_cnt_d [6];
    logic [4:0]      db_prev_q;
    logic [3:0]      pulse_q;
    logic            giro_q;

    logic [0:0]      state_q, state_d;
    logic [LP_W-1:0] hold_q, hold_d;
    logic            long_done_q, long_done_d;
    logic [3:0]      count_q, count_d;
    logic            test_fall;
    logic            test_active;

    assign raw_vec = {raw_giro, raw_test_n, raw_play_n, raw_feed_n, raw_awake_n, raw_sleep_n};
    assign pressed = sync2_q ^ RAW_IDLE;

    // A channel's level only moves after DEBOUNCE_CYCLES consecutive samples
    // disagreeing with it; any agreeing sample restarts the qualification.
    always_comb begin
        db_d = db_q;
        for (int c = 0; c < 6; c++) begin
            db_cnt_d[c] = '0;
            if (pressed[c] != db_q[c]) begin
                if (db_cnt_q[c] == DB_LAST) begin
                    db_d[c] = pressed[c];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + DB_W'(1);
                end
            end
        end
    end

    assign test_fall   = db_prev_q[CH_TEST] & ~db_q[CH_TEST];
    assign test_active = (state_q == ST_TEST);

    // Hold counter saturates at the toggle point; long_done keeps the release
    // that ends a long press from also counting as a short press.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        count_d     = count_q;
        if (db_q[CH_TEST]) begin
            if (!long_done_q) begin
                if (hold_q == LP_LAST) begin
                    long_done_d = 1'b1;
                    if (state_q == ST_NORMAL) begin
                        state_d = ST_TEST;
                        count_d = '0;
                    end else begin
                        state_d = ST_NORMAL;
                    end
                end else begin
                    hold_d = hold_q + LP_W'(1);
                end
            end
        end else begin
            hold_d      = '0;
            long_done_d = 1'b0;
            if (test_fall && !long_done_q && test_active) begin
                count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= RAW_IDLE;
            sync2_q     <= RAW_IDLE;
            db_q        <= '0;
            db_prev_q   <= '0;
            pulse_q     <= '0;
            giro_q      <= 1'b0;
            state_q     <= ST_NORMAL;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            count_q     <= '0;
            for (int c = 0; c < 6; c++) begin
                db_cnt_q[c] <= '0;
            end
        end else begin
            sync1_q     <= raw_vec;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_prev_q   <= db_q[4:0];
            pulse_q     <= db_q[3:0] & ~db_prev_q[3:0];
            giro_q      <= db_q[CH_GIRO];
            state_q     <= state_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            count_q     <= count_d;
            for (int c = 0; c < 6; c++) begin
                db_cnt_q[c] <= db_cnt_d[c];
            end
        end
    end

    // Command pulses are masked while in test mode, so presses there are lost.
    assign botonSleep = pulse_q[0] & ~test_active;
    assign botonAwake = pulse_q[1] & ~test_active;
    assign botonFeed  = pulse_q[2] & ~test_active;
    assign botonPlay  = pulse_q[3] & ~test_active;
    assign giro       = giro_q;
    assign botonTest  = test_active;
    assign BpulseTest = count_q;

endmodule

// File: tb/tb_button_frontend.sv
// tb/tb_button_frontend.sv - self-checking bench for button_frontend with a behavioural model
//
// Purpose: drives directed and randomized pin activity into button_frontend
// (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16) and checks every output each cycle
// against a sample-history model, plus literal expectations for key scenarios.
// Ports: none (top-level bench).
module tb_button_frontend;

    localparam int D = 4;
    localparam int L = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_n = 5'b11111;
    logic       raw_giro = 1'b0;
    logic       botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest;
    logic [3:0] BpulseTest;

    int n_cmp = 0;
    int n_bad = 0;
    int pc [4];
    int giro_hi = 0;

    // Model state: hist[c][k] is the pressed value sampled k edges ago.
    bit hist [6][D+2];
    bit m_db [6];
    bit m_rose [6];
    bit m_fell [6];
    bit m_pulse [4];
    bit m_giro;
    bit m_test;
    int m_cnt;
    int run;

    always #5 clk = ~clk;

    button_frontend #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
        .clk(clk), .rst(rst),
        .raw_sleep_n(btn_n[0]), .raw_awake_n(btn_n[1]), .raw_feed_n(btn_n[2]),
        .raw_play_n(btn_n[3]), .raw_test_n(btn_n[4]), .raw_giro(raw_giro),
        .botonSleep(botonSleep), .botonAwake(botonAwake), .botonFeed(botonFeed),
        .botonPlay(botonPlay), .giro(giro), .botonTest(botonTest), .BpulseTest(BpulseTest)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit p [6];
        bit o_db [6];
        bit o_rose [6];
        bit o_fell [6];
        bit flip;
        p[0] = !btn_n[0]; p[1] = !btn_n[1]; p[2] = !btn_n[2];
        p[3] = !btn_n[3]; p[4] = !btn_n[4]; p[5] = raw_giro;
        o_db = m_db; o_rose = m_rose; o_fell = m_fell;
        if (rst) begin
            for (int c = 0; c < 6; c++) begin
                m_db[c] = 0; m_rose[c] = 0; m_fell[c] = 0;
                for (int k = 0; k < D + 2; k++) hist[c][k] = 0;
            end
            for (int c = 0; c < 4; c++) m_pulse[c] = 0;
            m_giro = 0; m_test = 0; m_cnt = 0; run = 0;
            return;
        end
        for (int c = 0; c < 6; c++) begin
            for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = p[c];
            // Level flips once the last D synchronised samples all disagree with it.
            flip = 1;
            for (int k = 2; k <= D + 1; k++) if (hist[c][k] == m_db[c]) flip = 0;
            m_rose[c] = flip && !m_db[c];
            m_fell[c] = flip && m_db[c];
            if (flip) m_db[c] = !m_db[c];
        end
        if (o_db[4]) begin
            run++;
            if (run == L) begin
                m_test = !m_test;
                if (m_test) m_cnt = 0;
            end
        end else begin
            if (o_fell[4] && run < L && m_test) m_cnt = (m_cnt + 1) % 10;
            run = 0;
        end
        for (int c = 0; c < 4; c++) m_pulse[c] = o_rose[c];
        m_giro = o_db[5];
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("sleep", botonSleep, m_pulse[0] && !m_test);
            check("awake", botonAwake, m_pulse[1] && !m_test);
            check("feed",  botonFeed,  m_pulse[2] && !m_test);
            check("play",  botonPlay,  m_pulse[3] && !m_test);
            check("giro",  giro,       m_giro);
            check("test",  botonTest,  m_test);
            check("count", BpulseTest, m_cnt);
            if (botonSleep === 1'b1) pc[0]++;
            if (botonAwake === 1'b1) pc[1]++;
            if (botonFeed  === 1'b1) pc[2]++;
            if (botonPlay  === 1'b1) pc[3]++;
            if (giro === 1'b1) giro_hi++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int ch, input int low, input int gap);
        btn_n[ch] = 1'b0;
        cyc(low);
        btn_n[ch] = 1'b1;
        cyc(gap);
    endtask

    initial begin
        int base;
        int dur [6];
        int tot;
        for (int c = 0; c < 4; c++) pc[c] = 0;

        // Reset state.
        cyc(3);
        check("rst_sleep", botonSleep, 0);
        check("rst_feed", botonFeed, 0);
        check("rst_giro", giro, 0);
        check("rst_test", botonTest, 0);
        check("rst_count", BpulseTest, 0);
        rst = 1'b0;
        cyc(5);

        // Reset asserted with feed held: pulse only after full requalification.
        rst = 1'b1;
        btn_n[2] = 1'b0;
        cyc(3);
        rst = 1'b0;
        base = pc[2];
        cyc(6);
        check("rstheld_early", pc[2] - base, 0);
        cyc(1);
        check("rstheld_pulse", botonFeed, 1);
        btn_n[2] = 1'b1;
        cyc(12);

        // Clean feed press: pulse exactly 7 cycles after the drive.
        base = pc[2];
        btn_n[2] = 1'b0;
        cyc(6);
        check("feed_before", botonFeed, 0);
        cyc(1);
        check("feed_at", botonFeed, 1);
        cyc(1);
        check("feed_after", botonFeed, 0);
        cyc(10);
        btn_n[2] = 1'b1;
        cyc(12);
        check("feed_one_pulse", pc[2] - base, 1);

        // Bounce on play and tilt.
        base = pc[3];
        for (int i = 0; i < 5; i++) begin
            btn_n[3] = 1'b0; cyc(2);
            btn_n[3] = 1'b1; cyc(2);
        end
        cyc(12);
        check("bounce_play", pc[3] - base, 0);
        base = giro_hi;
        for (int i = 0; i < 5; i++) begin
            raw_giro = 1'b1; cyc(3);
            raw_giro = 1'b0; cyc(3);
        end
        cyc(12);
        check("bounce_giro", giro_hi - base, 0);

        // Test entry and three short presses, then exit.
        press(4, 30, 12);
        check("enter_test", botonTest, 1);
        check("enter_count", BpulseTest, 0);
        for (int i = 1; i <= 3; i++) begin
            press(4, 8, 12);
            check("short_count", BpulseTest, i);
        end
        press(4, 30, 12);
        check("exit_test", botonTest, 0);
        check("exit_hold", BpulseTest, 3);

        // Wrap and suppression.
        press(4, 30, 12);
        check("reenter_clear", BpulseTest, 0);
        for (int i = 1; i <= 10; i++) begin
            press(4, 8, 12);
            check("wrap_count", BpulseTest, i % 10);
        end
        tot = pc[0] + pc[1] + pc[2] + pc[3];
        for (int ch = 0; ch < 4; ch++) press(ch, 8, 12);
        check("suppressed", pc[0] + pc[1] + pc[2] + pc[3] - tot, 0);
        press(4, 30, 12);
        check("exit2", botonTest, 0);
        base = pc[3];
        press(3, 8, 12);
        check("play_after_exit", pc[3] - base, 1);

        // Simultaneous presses and short test press in NORMAL.
        btn_n[0] = 1'b0;
        btn_n[2] = 1'b0;
        cyc(7);
        check("sim_sleep", botonSleep, 1);
        check("sim_feed", botonFeed, 1);
        btn_n[0] = 1'b1;
        btn_n[2] = 1'b1;
        cyc(12);
        press(4, 8, 12);
        check("normal_short", BpulseTest, 0);
        check("normal_short_test", botonTest, 0);

        // Randomized activity with occasional resets; model checks every cycle.
        for (int c = 0; c < 6; c++) dur[c] = $urandom_range(1, 20);
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 1499) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
            for (int c = 0; c < 6; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    if (c == 5) raw_giro = ~raw_giro;
                    else btn_n[c] = ~btn_n[c];
                    if ($urandom_range(0, 1) == 0) dur[c] = $urandom_range(1, 6);
                    else if (c == 4 && $urandom_range(0, 2) == 0) dur[c] = $urandom_range(20, 40);
                    else dur[c] = $urandom_range(6, 24);
                end
            end
        end
        rst = 1'b0;
        btn_n = 5'b11111;
        raw_giro = 1'b0;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
